// File: rtl/fetch_entry_queue_if.sv
// Fetch-entry handshake bundle: fetch/realign pushes entries in, decode pops up to two per cycle.
// An entry transfers on a rising clock edge where its valid and ready are both high; valid never waits on ready.
interface fetch_entry_queue_if #(
   parameter type fetch_entry_t = logic
);
   logic               push_valid_i;
   fetch_entry_t       push_entry_i;
   logic               push_ready_o;
   fetch_entry_t [1:0] fetch_entry_o;
   logic [1:0]         fetch_entry_valid_o;
   logic [1:0]         fetch_entry_ready_i;

   modport master (
      input  push_valid_i, push_entry_i, fetch_entry_ready_i,
      output push_ready_o, fetch_entry_o, fetch_entry_valid_o
   );

   modport slave (
      output push_valid_i, push_entry_i, fetch_entry_ready_i,
      input  push_ready_o, fetch_entry_o, fetch_entry_valid_o
   );
endinterface

// File: rtl/fetch_entry_queue.sv
// In-order circular FIFO of fetch entries presenting the two oldest entries to decode.
// Flush empties the queue but keeps storage; reset also clears storage.
module fetch_entry_queue #(
   parameter int unsigned CVA6Cfg       = 0,
   parameter type         fetch_entry_t = logic,
   parameter int unsigned DEPTH         = 4,
   parameter bit          SUPERSCALAR   = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   fetch_entry_queue_if.master           fe_if,
   output logic [$clog2(DEPTH):0]        count_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             valid0, valid1;
   logic             pop0, pop1, push;
   logic [CNT_W-1:0] npop;

   assign valid0 = (count_q != '0);
   assign valid1 = SUPERSCALAR && (count_q >= CNT_W'(2));

   assign fe_if.fetch_entry_valid_o = {valid1, valid0};
   assign fe_if.fetch_entry_o[0]    = mem_q[rd_ptr_q];
   assign fe_if.fetch_entry_o[1]    = mem_q[rd_ptr_q + PTR_W'(1)];
   // Space is judged on the registered count only, so a pop never frees room for a same-cycle push.
   assign fe_if.push_ready_o        = (count_q < DEPTH_C);
   assign count_o                   = count_q;

   assign pop0 = valid0 & fe_if.fetch_entry_ready_i[0];
   assign pop1 = pop0 & valid1 & fe_if.fetch_entry_ready_i[1];
   assign npop = CNT_W'(pop0) + CNT_W'(pop1);
   assign push = fe_if.push_valid_i & fe_if.push_ready_o & ~flush_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(npop);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         count_d  = count_q + CNT_W'(push) - npop;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= fe_if.push_entry_i;
         end
      end
   end
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed bench for fetch_entry_queue: DEPTH=4, SUPERSCALAR=1, 32-bit entries holding an address.
module tb_fetch_entry_queue;
   typedef logic [31:0] entry_t;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [2:0] count;
   int         errors;
   int         checks;

   fetch_entry_queue_if #(.fetch_entry_t(entry_t)) fe_if ();

   fetch_entry_queue #(
      .fetch_entry_t(entry_t),
      .DEPTH        (4),
      .SUPERSCALAR  (1'b1)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .flush_i(flush),
      .fe_if  (fe_if),
      .count_o(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle past it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input entry_t e, input logic [1:0] rdy);
      fe_if.push_valid_i        = pv;
      fe_if.push_entry_i        = e;
      fe_if.fetch_entry_ready_i = rdy;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      flush  = 1'b0;
      drive(1'b0, 32'h0, 2'b00);
      step();
      step();
      check("rst_valid", 32'(fe_if.fetch_entry_valid_o), 32'h0);
      check("rst_ready", 32'(fe_if.push_ready_o), 32'h1);
      check("rst_count", 32'(count), 32'h0);
      check("rst_entry0", fe_if.fetch_entry_o[0], 32'h0);

      // Latency: A visible one edge after its push
      rst = 1'b0;
      drive(1'b1, 32'h8000_0000, 2'b00);
      check("no_passthru", 32'(fe_if.fetch_entry_valid_o), 32'h0);
      step();
      check("lat_valid", 32'(fe_if.fetch_entry_valid_o), 32'h1);
      check("lat_entry0", fe_if.fetch_entry_o[0], 32'h8000_0000);
      check("lat_count", 32'(count), 32'h1);

      // Fill with B, C, D
      drive(1'b1, 32'h8000_0004, 2'b00); step();
      drive(1'b1, 32'h8000_0008, 2'b00); step();
      drive(1'b1, 32'h8000_000C, 2'b00); step();
      drive(1'b0, 32'h0, 2'b00);
      check("full_count", 32'(count), 32'h4);
      check("full_ready", 32'(fe_if.push_ready_o), 32'h0);
      check("full_valid", 32'(fe_if.fetch_entry_valid_o), 32'h3);
      check("full_entry1", fe_if.fetch_entry_o[1], 32'h8000_0004);

      // E offered while full and A popping: E rejected
      drive(1'b1, 32'h8000_0010, 2'b01);
      check("full_pop_ready", 32'(fe_if.push_ready_o), 32'h0);
      step();
      drive(1'b0, 32'h0, 2'b00);
      check("after_full_count", 32'(count), 32'h3);
      check("after_full_ready", 32'(fe_if.push_ready_o), 32'h1);
      check("after_full_entry0", fe_if.fetch_entry_o[0], 32'h8000_0004);

      // Dual pop of B, C leaves D
      drive(1'b0, 32'h0, 2'b11);
      step();
      drive(1'b0, 32'h0, 2'b00);
      check("dual_entry0", fe_if.fetch_entry_o[0], 32'h8000_000C);
      check("dual_count", 32'(count), 32'h1);
      check("dual_valid", 32'(fe_if.fetch_entry_valid_o), 32'h1);

      // F lands in mem[0]: rd_ptr=3 with D in slot 0 and F wrapping into slot 1
      drive(1'b1, 32'h8000_0014, 2'b00); step();
      drive(1'b0, 32'h0, 2'b00);
      check("wrap_entry0", fe_if.fetch_entry_o[0], 32'h8000_000C);
      check("wrap_entry1", fe_if.fetch_entry_o[1], 32'h8000_0014);
      check("wrap_valid", 32'(fe_if.fetch_entry_valid_o), 32'h3);

      drive(1'b0, 32'h0, 2'b10); step();
      check("rdy10_count", 32'(count), 32'h2);
      check("rdy10_entry0", fe_if.fetch_entry_o[0], 32'h8000_000C);

      drive(1'b0, 32'h0, 2'b11); step();
      drive(1'b0, 32'h0, 2'b00);
      check("wrap_empty_count", 32'(count), 32'h0);
      check("wrap_empty_valid", 32'(fe_if.fetch_entry_valid_o), 32'h0);

      // G goes to mem[1]; slot 0 shows it only if rd_ptr wrapped to 1
      drive(1'b1, 32'h8000_0018, 2'b00); step();
      check("rdptr1_entry0", fe_if.fetch_entry_o[0], 32'h8000_0018);
      drive(1'b1, 32'h8000_001C, 2'b00); step();
      drive(1'b1, 32'h8000_0020, 2'b00); step();
      check("pre_flush_count", 32'(count), 32'h3);

      // Flush with J offered and both slots ready
      flush = 1'b1;
      drive(1'b1, 32'h8000_0024, 2'b11);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 2'b00);
      check("flush_count", 32'(count), 32'h0);
      check("flush_valid", 32'(fe_if.fetch_entry_valid_o), 32'h0);
      check("flush_ready", 32'(fe_if.push_ready_o), 32'h1);
      check("flush_mem0_kept", fe_if.fetch_entry_o[0], 32'h8000_0014);

      drive(1'b1, 32'h8000_0028, 2'b00); step();
      check("post_flush_entry0", fe_if.fetch_entry_o[0], 32'h8000_0028);
      check("post_flush_count", 32'(count), 32'h1);
      drive(1'b1, 32'h8000_002C, 2'b00); step();
      check("pre_rst_count", 32'(count), 32'h2);

      // Reset while M is pushed
      rst = 1'b1;
      drive(1'b1, 32'h8000_0030, 2'b00);
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 2'b00);
      check("mid_rst_count", 32'(count), 32'h0);
      check("mid_rst_entry0", fe_if.fetch_entry_o[0], 32'h0);
      check("mid_rst_entry1", fe_if.fetch_entry_o[1], 32'h0);
      check("mid_rst_valid", 32'(fe_if.fetch_entry_valid_o), 32'h0);

      drive(1'b1, 32'h8000_0034, 2'b00); step();
      drive(1'b0, 32'h0, 2'b00);
      check("post_rst_entry0", fe_if.fetch_entry_o[0], 32'h8000_0034);
      check("post_rst_valid", 32'(fe_if.fetch_entry_valid_o), 32'h1);

      // Ready on the invalid slot 1 only pops the single entry
      drive(1'b0, 32'h0, 2'b11); step();
      drive(1'b0, 32'h0, 2'b00);
      check("single_pop_count", 32'(count), 32'h0);
      check("single_pop_ready", 32'(fe_if.push_ready_o), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
